// File: rtl/nasti_pkg.sv
// Shared NASTI request payload and width-conversion helpers used by the
// narrower reader and writer.
package nasti_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
    } nasti_req_t;

    // Narrow beats generated per wide beat.
    function automatic logic [7:0] ratio(input logic [2:0] size, input logic [2:0] scs);
        return (size > scs) ? (8'(1) << (size - scs)) : 8'd1;
    endfunction

    function automatic logic [2:0] slave_size(input logic [2:0] size, input logic [2:0] scs);
        return (size > scs) ? scs : size;
    endfunction

    function automatic logic [7:0] slave_step(input logic [2:0] size, input logic [2:0] scs);
        return 8'(1) << slave_size(size, scs);
    endfunction

    // Unaligned starts skip the narrow lanes below the start address.
    function automatic logic [15:0] slave_len(input logic [7:0]  len,
                                              input logic [15:0] addr,
                                              input logic [2:0]  size,
                                              input logic [2:0]  scs);
        logic [2:0]  d;
        logic [15:0] mask;
        logic [15:0] lead;
        if (size > scs) begin
            d    = size - scs;
            mask = (16'(1) << d) - 16'(1);
            lead = (addr >> scs) & mask;
            return ((16'(len) + 16'(1)) << d) - lead - 16'(1);
        end
        return 16'(len);
    endfunction

endpackage

// File: rtl/nasti_narrower_w_slicer.sv
// One-entry wide W buffer that emits narrow slices, advancing the lane by
// address until the wide beat is exhausted.
module nasti_narrower_w_slicer
    import nasti_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned MASTER_DATA_WIDTH = 64,
    parameter int unsigned SLAVE_DATA_WIDTH  = 32,
    parameter int unsigned USER_WIDTH        = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           init,
    input  logic [ADDR_WIDTH-1:0]          init_addr,
    input  logic [2:0]                     init_size,
    input  logic                           enable,
    input  logic [MASTER_DATA_WIDTH-1:0]   m_data,
    input  logic [MASTER_DATA_WIDTH/8-1:0] m_strb,
    input  logic [USER_WIDTH-1:0]          m_user,
    input  logic                           m_valid,
    output logic                           m_ready,
    output logic [SLAVE_DATA_WIDTH-1:0]    s_data,
    output logic [SLAVE_DATA_WIDTH/8-1:0]  s_strb,
    output logic [USER_WIDTH-1:0]          s_user,
    output logic                           s_valid,
    input  logic                           s_ready
);

    localparam int unsigned MCS    = $clog2(MASTER_DATA_WIDTH / 8);
    localparam int unsigned SCS    = $clog2(SLAVE_DATA_WIDTH / 8);
    localparam int unsigned LANE_W = MCS - SCS;
    localparam int unsigned SW     = SLAVE_DATA_WIDTH;
    localparam int unsigned SSW    = SLAVE_DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0]          r_addr;
    logic [2:0]                     r_size;
    logic [MASTER_DATA_WIDTH-1:0]   buf_data;
    logic [MASTER_DATA_WIDTH/8-1:0] buf_strb;
    logic [USER_WIDTH-1:0]          buf_user;
    logic                           buf_valid;
    logic [ADDR_WIDTH-1:0]          step;
    logic [ADDR_WIDTH-1:0]          next_addr;
    logic [ADDR_WIDTH-1:0]          size_mask;
    logic                           drop;
    logic [LANE_W-1:0]              lane;

    assign lane      = r_addr[MCS-1:SCS];
    assign step      = ADDR_WIDTH'(slave_step(r_size, 3'(SCS)));
    assign next_addr = (r_addr & ~(step - ADDR_WIDTH'(1))) + step;
    assign size_mask = (ADDR_WIDTH'(1) << r_size) - ADDR_WIDTH'(1);
    assign drop      = (r_size <= 3'(SCS)) || ((next_addr & size_mask) == '0);

    assign m_ready = enable && !buf_valid;
    assign s_valid = buf_valid;
    assign s_data  = buf_data[32'(lane) * SW +: SW];
    assign s_strb  = buf_strb[32'(lane) * SSW +: SSW];
    assign s_user  = buf_user;

    // Fill and drain are mutually exclusive: fill needs an empty buffer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr    <= '0;
            r_size    <= '0;
            buf_data  <= '0;
            buf_strb  <= '0;
            buf_user  <= '0;
            buf_valid <= 1'b0;
        end else if (init) begin
            r_addr    <= init_addr;
            r_size    <= init_size;
            buf_valid <= 1'b0;
        end else if (m_valid && m_ready) begin
            buf_data  <= m_data;
            buf_strb  <= m_strb;
            buf_user  <= m_user;
            buf_valid <= 1'b1;
        end else if (s_valid && s_ready) begin
            r_addr <= next_addr;
            if (drop) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/nasti_narrower_writer.sv
// NASTI write-channel width converter: one wide-master burst at a time is
// re-issued to a narrower slave as a longer burst of narrow beats.
module nasti_narrower_writer
    import nasti_pkg::*;
#(
    parameter int unsigned ID_WIDTH          = 2,
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned MASTER_DATA_WIDTH = 64,
    parameter int unsigned SLAVE_DATA_WIDTH  = 32,
    parameter int unsigned USER_WIDTH        = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [ID_WIDTH-1:0]            master_aw_id,
    input  logic [ADDR_WIDTH-1:0]          master_aw_addr,
    input  logic [7:0]                     master_aw_len,
    input  logic [2:0]                     master_aw_size,
    input  logic [1:0]                     master_aw_burst,
    input  logic                           master_aw_lock,
    input  logic [3:0]                     master_aw_cache,
    input  logic [2:0]                     master_aw_prot,
    input  logic [3:0]                     master_aw_qos,
    input  logic [3:0]                     master_aw_region,
    input  logic [USER_WIDTH-1:0]          master_aw_user,
    input  logic                           master_aw_valid,
    output logic                           master_aw_ready,
    input  logic [MASTER_DATA_WIDTH-1:0]   master_w_data,
    input  logic [MASTER_DATA_WIDTH/8-1:0] master_w_strb,
    input  logic                           master_w_last,
    input  logic [USER_WIDTH-1:0]          master_w_user,
    input  logic                           master_w_valid,
    output logic                           master_w_ready,
    output logic [ID_WIDTH-1:0]            master_b_id,
    output logic [1:0]                     master_b_resp,
    output logic [USER_WIDTH-1:0]          master_b_user,
    output logic                           master_b_valid,
    input  logic                           master_b_ready,
    output logic [ID_WIDTH-1:0]            slave_aw_id,
    output logic [ADDR_WIDTH-1:0]          slave_aw_addr,
    output logic [7:0]                     slave_aw_len,
    output logic [2:0]                     slave_aw_size,
    output logic [1:0]                     slave_aw_burst,
    output logic                           slave_aw_lock,
    output logic [3:0]                     slave_aw_cache,
    output logic [2:0]                     slave_aw_prot,
    output logic [3:0]                     slave_aw_qos,
    output logic [3:0]                     slave_aw_region,
    output logic [USER_WIDTH-1:0]          slave_aw_user,
    output logic                           slave_aw_valid,
    input  logic                           slave_aw_ready,
    output logic [SLAVE_DATA_WIDTH-1:0]    slave_w_data,
    output logic [SLAVE_DATA_WIDTH/8-1:0]  slave_w_strb,
    output logic                           slave_w_last,
    output logic [USER_WIDTH-1:0]          slave_w_user,
    output logic                           slave_w_valid,
    input  logic                           slave_w_ready,
    input  logic [ID_WIDTH-1:0]            slave_b_id,
    input  logic [1:0]                     slave_b_resp,
    input  logic [USER_WIDTH-1:0]          slave_b_user,
    input  logic                           slave_b_valid,
    output logic                           slave_b_ready
);

    localparam int unsigned SCS  = $clog2(SLAVE_DATA_WIDTH / 8);
    localparam logic [2:0]  SCS3 = 3'(SCS);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t                  state;
    state_t                  state_nxt;
    nasti_req_t              r_req;
    logic [ID_WIDTH-1:0]     r_id;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [USER_WIDTH-1:0]   r_user;
    logic [7:0]              r_slen;
    logic [7:0]              s_cnt;
    logic [7:0]              m_cnt;
    logic [15:0]             slen_full;
    logic                    aw_hs;
    logic                    saw_hs;
    logic                    mw_hs;
    logic                    sw_hs;
    logic                    sb_hs;
    logic                    mb_hs;

    assign master_aw_ready = (state == S_IDLE);
    assign slave_aw_valid  = (state == S_AW);
    assign slave_b_ready   = (state == S_B) && !master_b_valid;

    assign aw_hs  = master_aw_valid && master_aw_ready;
    assign saw_hs = slave_aw_valid && slave_aw_ready;
    assign mw_hs  = master_w_valid && master_w_ready;
    assign sw_hs  = slave_w_valid && slave_w_ready;
    assign sb_hs  = slave_b_valid && slave_b_ready;
    assign mb_hs  = master_b_valid && master_b_ready;

    assign slen_full = slave_len(master_aw_len, 16'(master_aw_addr), master_aw_size, SCS3);

    assign slave_aw_id     = r_id;
    assign slave_aw_addr   = r_addr;
    assign slave_aw_len    = r_slen;
    assign slave_aw_size   = slave_size(r_req.size, SCS3);
    assign slave_aw_burst  = r_req.burst;
    assign slave_aw_lock   = r_req.lock;
    assign slave_aw_cache  = r_req.cache;
    assign slave_aw_prot   = r_req.prot;
    assign slave_aw_qos    = r_req.qos;
    assign slave_aw_region = r_req.region;
    assign slave_aw_user   = r_user;
    assign slave_w_last    = (s_cnt == r_slen);
    assign master_b_id     = r_id;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (aw_hs)                 state_nxt = S_AW;
            S_AW:    if (saw_hs)                state_nxt = S_W;
            S_W:     if (sw_hs && slave_w_last) state_nxt = S_B;
            S_B:     if (mb_hs)                 state_nxt = S_IDLE;
            default:                            state_nxt = S_IDLE;
        endcase
    end

    // Request capture and beat counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_req  <= '0;
            r_id   <= '0;
            r_addr <= '0;
            r_user <= '0;
            r_slen <= '0;
            s_cnt  <= '0;
            m_cnt  <= '0;
        end else if (aw_hs) begin
            r_req  <= '{len: master_aw_len, size: master_aw_size, burst: master_aw_burst,
                        lock: master_aw_lock, cache: master_aw_cache, prot: master_aw_prot,
                        qos: master_aw_qos, region: master_aw_region};
            r_id   <= master_aw_id;
            r_addr <= master_aw_addr;
            r_user <= master_aw_user;
            r_slen <= slen_full[7:0];
            s_cnt  <= '0;
            m_cnt  <= '0;
        end else begin
            if (sw_hs) s_cnt <= s_cnt + 8'd1;
            if (mw_hs) m_cnt <= m_cnt + 8'd1;
        end
    end

    // Slave response is held until the master takes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            master_b_valid <= 1'b0;
            master_b_resp  <= '0;
            master_b_user  <= '0;
        end else if (sb_hs) begin
            master_b_valid <= 1'b1;
            master_b_resp  <= slave_b_resp;
            master_b_user  <= slave_b_user;
        end else if (mb_hs) begin
            master_b_valid <= 1'b0;
        end
    end

    nasti_narrower_w_slicer #(
        .ADDR_WIDTH        (ADDR_WIDTH),
        .MASTER_DATA_WIDTH (MASTER_DATA_WIDTH),
        .SLAVE_DATA_WIDTH  (SLAVE_DATA_WIDTH),
        .USER_WIDTH        (USER_WIDTH)
    ) u_slicer (
        .clk       (clk),
        .rstn      (rstn),
        .init      (aw_hs),
        .init_addr (master_aw_addr),
        .init_size (master_aw_size),
        .enable    (state == S_W),
        .m_data    (master_w_data),
        .m_strb    (master_w_strb),
        .m_user    (master_w_user),
        .m_valid   (master_w_valid),
        .m_ready   (master_w_ready),
        .s_data    (slave_w_data),
        .s_strb    (slave_w_strb),
        .s_user    (slave_w_user),
        .s_valid   (slave_w_valid),
        .s_ready   (slave_w_ready)
    );

`ifndef SYNTHESIS
    // Protocol misuse that this converter cannot handle.
    always @(posedge clk) begin
        if (rstn) begin
            if (aw_hs) begin
                assert (master_aw_burst == BURST_INCR)
                    else $fatal(1, "nasti_narrower_writer: only INCR bursts supported");
                assert (slen_full <= 16'd255)
                    else $fatal(1, "nasti_narrower_writer: narrow burst length exceeds 256 beats");
            end
            if (mw_hs) begin
                assert (master_w_last == (m_cnt == r_req.len))
                    else $fatal(1, "nasti_narrower_writer: master_w_last out of place");
            end
            if (sb_hs) begin
                assert (slave_b_id == r_id)
                    else $fatal(1, "nasti_narrower_writer: slave_b_id does not match request");
            end
        end
    end
`endif

endmodule

// File: tb/tb_nasti_narrower_writer.sv
// Directed bench for the 64->32 bit NASTI write narrower.
module tb_nasti_narrower_writer;

    localparam int BUDGET = 200;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  master_aw_id;
    logic [31:0] master_aw_addr;
    logic [7:0]  master_aw_len;
    logic [2:0]  master_aw_size;
    logic [1:0]  master_aw_burst;
    logic        master_aw_lock;
    logic [3:0]  master_aw_cache;
    logic [2:0]  master_aw_prot;
    logic [3:0]  master_aw_qos;
    logic [3:0]  master_aw_region;
    logic [0:0]  master_aw_user;
    logic        master_aw_valid;
    logic        master_aw_ready;
    logic [63:0] master_w_data;
    logic [7:0]  master_w_strb;
    logic        master_w_last;
    logic [0:0]  master_w_user;
    logic        master_w_valid;
    logic        master_w_ready;
    logic [1:0]  master_b_id;
    logic [1:0]  master_b_resp;
    logic [0:0]  master_b_user;
    logic        master_b_valid;
    logic        master_b_ready;
    logic [1:0]  slave_aw_id;
    logic [31:0] slave_aw_addr;
    logic [7:0]  slave_aw_len;
    logic [2:0]  slave_aw_size;
    logic [1:0]  slave_aw_burst;
    logic        slave_aw_lock;
    logic [3:0]  slave_aw_cache;
    logic [2:0]  slave_aw_prot;
    logic [3:0]  slave_aw_qos;
    logic [3:0]  slave_aw_region;
    logic [0:0]  slave_aw_user;
    logic        slave_aw_valid;
    logic        slave_aw_ready;
    logic [31:0] slave_w_data;
    logic [3:0]  slave_w_strb;
    logic        slave_w_last;
    logic [0:0]  slave_w_user;
    logic        slave_w_valid;
    logic        slave_w_ready;
    logic [1:0]  slave_b_id;
    logic [1:0]  slave_b_resp;
    logic [0:0]  slave_b_user;
    logic        slave_b_valid;
    logic        slave_b_ready;

    int checks = 0;
    int errors = 0;

    logic [1:0]  cap_aw_id;
    logic [31:0] cap_aw_addr;
    logic [7:0]  cap_aw_len;
    logic [2:0]  cap_aw_size;
    logic [3:0]  cap_aw_cache;
    logic [1:0]  cap_b_resp;
    logic [1:0]  cap_b_id;
    logic [31:0] got_data[$];
    logic [3:0]  got_strb[$];
    logic        got_last[$];
    logic [63:0] mw_data[8];
    logic [7:0]  mw_strb[8];
    int          stall_violations;

    always #5 clk = ~clk;

    nasti_narrower_writer dut (
        .clk(clk), .rstn(rstn),
        .master_aw_id(master_aw_id), .master_aw_addr(master_aw_addr), .master_aw_len(master_aw_len),
        .master_aw_size(master_aw_size), .master_aw_burst(master_aw_burst), .master_aw_lock(master_aw_lock),
        .master_aw_cache(master_aw_cache), .master_aw_prot(master_aw_prot), .master_aw_qos(master_aw_qos),
        .master_aw_region(master_aw_region), .master_aw_user(master_aw_user),
        .master_aw_valid(master_aw_valid), .master_aw_ready(master_aw_ready),
        .master_w_data(master_w_data), .master_w_strb(master_w_strb), .master_w_last(master_w_last),
        .master_w_user(master_w_user), .master_w_valid(master_w_valid), .master_w_ready(master_w_ready),
        .master_b_id(master_b_id), .master_b_resp(master_b_resp), .master_b_user(master_b_user),
        .master_b_valid(master_b_valid), .master_b_ready(master_b_ready),
        .slave_aw_id(slave_aw_id), .slave_aw_addr(slave_aw_addr), .slave_aw_len(slave_aw_len),
        .slave_aw_size(slave_aw_size), .slave_aw_burst(slave_aw_burst), .slave_aw_lock(slave_aw_lock),
        .slave_aw_cache(slave_aw_cache), .slave_aw_prot(slave_aw_prot), .slave_aw_qos(slave_aw_qos),
        .slave_aw_region(slave_aw_region), .slave_aw_user(slave_aw_user),
        .slave_aw_valid(slave_aw_valid), .slave_aw_ready(slave_aw_ready),
        .slave_w_data(slave_w_data), .slave_w_strb(slave_w_strb), .slave_w_last(slave_w_last),
        .slave_w_user(slave_w_user), .slave_w_valid(slave_w_valid), .slave_w_ready(slave_w_ready),
        .slave_b_id(slave_b_id), .slave_b_resp(slave_b_resp), .slave_b_user(slave_b_user),
        .slave_b_valid(slave_b_valid), .slave_b_ready(slave_b_ready)
    );

    task automatic send_aw(input logic [1:0] id, input logic [31:0] addr,
                           input logic [2:0] size, input logic [7:0] len);
        int n = 0;
        @(negedge clk);
        master_aw_id = id; master_aw_addr = addr; master_aw_size = size; master_aw_len = len;
        master_aw_valid = 1'b1;
        while (!master_aw_ready && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) begin
            checks++; errors++;
            $display("FAIL aw_timeout: master_aw_ready stayed %b, required 1", master_aw_ready);
        end else begin
            @(posedge clk); @(negedge clk);
        end
        master_aw_valid = 1'b0;
    endtask

    task automatic accept_slave_aw();
        int n = 0;
        while (!slave_aw_valid && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) begin
            checks++; errors++;
            $display("FAIL slave_aw_timeout: slave_aw_valid stayed %b, required 1", slave_aw_valid);
        end else begin
            cap_aw_id = slave_aw_id; cap_aw_addr = slave_aw_addr; cap_aw_len = slave_aw_len;
            cap_aw_size = slave_aw_size; cap_aw_cache = slave_aw_cache;
            slave_aw_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            slave_aw_ready = 1'b0;
        end
    endtask

    task automatic drive_master_w(input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            int n = 0;
            master_w_data = mw_data[i]; master_w_strb = mw_strb[i];
            master_w_last = (i == nbeats - 1); master_w_valid = 1'b1;
            while (!master_w_ready && n < BUDGET) begin @(negedge clk); n++; end
            if (n >= BUDGET) begin
                checks++; errors++;
                $display("FAIL master_w_timeout: beat %0d master_w_ready %b, required 1", i, master_w_ready);
                break;
            end
            @(posedge clk); @(negedge clk);
        end
        master_w_valid = 1'b0;
        master_w_last  = 1'b0;
    endtask

    task automatic collect_slave_w(input int stall_after, input int stall_cycles);
        int  acc  = 0;
        int  st   = 0;
        int  n    = 0;
        bit  done = 1'b0;
        while (!done && n < BUDGET) begin
            @(negedge clk); n++;
            if (acc == stall_after && st < stall_cycles) begin
                slave_w_ready = 1'b0; st++;
                if (master_w_ready !== 1'b0) stall_violations++;
            end else begin
                slave_w_ready = 1'b1;
                if (slave_w_valid) begin
                    got_data.push_back(slave_w_data);
                    got_strb.push_back(slave_w_strb);
                    got_last.push_back(slave_w_last);
                    acc++;
                    if (slave_w_last) done = 1'b1;
                end
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL slave_w_timeout: %0d beats seen without last", acc);
        end
        @(posedge clk); @(negedge clk);
        slave_w_ready = 1'b0;
    endtask

    task automatic do_b(input logic [1:0] resp);
        int n = 0;
        slave_b_id = cap_aw_id; slave_b_resp = resp; slave_b_valid = 1'b1;
        while (!slave_b_ready && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) begin
            checks++; errors++;
            $display("FAIL slave_b_timeout: slave_b_ready %b, required 1", slave_b_ready);
        end else begin
            @(posedge clk); @(negedge clk);
        end
        slave_b_valid = 1'b0;
        n = 0;
        while (!master_b_valid && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) begin
            checks++; errors++;
            $display("FAIL master_b_timeout: master_b_valid %b, required 1", master_b_valid);
            cap_b_resp = 2'bxx; cap_b_id = 2'bxx;
        end else begin
            cap_b_resp = master_b_resp; cap_b_id = master_b_id;
            master_b_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            master_b_ready = 1'b0;
        end
    endtask

    task automatic run_burst(input logic [1:0] id, input logic [31:0] addr, input logic [2:0] size,
                             input logic [7:0] len, input int nbeats, input int stall_after,
                             input int stall_cycles, input logic [1:0] resp);
        send_aw(id, addr, size, len);
        accept_slave_aw();
        got_data.delete(); got_strb.delete(); got_last.delete();
        stall_violations = 0;
        fork
            drive_master_w(nbeats);
            collect_slave_w(stall_after, stall_cycles);
        join
        do_b(resp);
    endtask

    task automatic load_ab();
        mw_data[0] = 64'h1111_2222_3333_4444; mw_strb[0] = 8'h3C;
        mw_data[1] = 64'h5555_6666_7777_8888; mw_strb[1] = 8'hF1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (master_aw_ready !== 1'b1) begin errors++; $display("FAIL reset_aw_ready: got %b want 1", master_aw_ready); end
        checks++; if (slave_aw_valid !== 1'b0) begin errors++; $display("FAIL reset_slave_aw_valid: got %b want 0", slave_aw_valid); end
        checks++; if (master_w_ready !== 1'b0) begin errors++; $display("FAIL reset_w_ready: got %b want 0", master_w_ready); end
        checks++; if (slave_w_valid !== 1'b0) begin errors++; $display("FAIL reset_slave_w_valid: got %b want 0", slave_w_valid); end
        checks++; if (slave_b_ready !== 1'b0) begin errors++; $display("FAIL reset_slave_b_ready: got %b want 0", slave_b_ready); end
        checks++; if (master_b_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b want 0", master_b_valid); end
        checks++; if (master_b_resp !== 2'b00) begin errors++; $display("FAIL reset_b_resp: got %b want 00", master_b_resp); end
    endtask

    task automatic check_ab_beats(input string tag);
        logic [31:0] exp_d[4];
        logic [3:0]  exp_s[4];
        exp_d = '{32'h3333_4444, 32'h1111_2222, 32'h7777_8888, 32'h5555_6666};
        exp_s = '{4'hC, 4'h3, 4'h1, 4'hF};
        checks++;
        if (got_data.size() != 4) begin errors++; $display("FAIL %s_beat_count: got %0d want 4", tag, got_data.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got_data.size()) begin
                errors++; $display("FAIL %s_beat%0d: missing", tag, i);
            end else if (got_data[i] !== exp_d[i] || got_strb[i] !== exp_s[i] || got_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL %s_beat%0d: got data %h strb %h last %b want data %h strb %h last %b",
                         tag, i, got_data[i], got_strb[i], got_last[i], exp_d[i], exp_s[i], i == 3);
            end
        end
    endtask

    task automatic test_aligned_burst();
        load_ab();
        run_burst(2'd1, 32'h0000_1000, 3'd3, 8'd1, 2, -1, 0, 2'b00);
        checks++; if (cap_aw_addr !== 32'h1000) begin errors++; $display("FAIL aligned_aw_addr: got %h want 1000", cap_aw_addr); end
        checks++; if (cap_aw_len !== 8'd3) begin errors++; $display("FAIL aligned_aw_len: got %0d want 3", cap_aw_len); end
        checks++; if (cap_aw_size !== 3'd2) begin errors++; $display("FAIL aligned_aw_size: got %0d want 2", cap_aw_size); end
        checks++; if (cap_aw_cache !== 4'h3 || cap_aw_id !== 2'd1) begin errors++; $display("FAIL aligned_aw_fwd: got cache %h id %0d want 3 1", cap_aw_cache, cap_aw_id); end
        check_ab_beats("aligned");
        checks++; if (cap_b_resp !== 2'b00 || cap_b_id !== 2'd1) begin errors++; $display("FAIL aligned_b: got resp %b id %0d want 00 1", cap_b_resp, cap_b_id); end
    endtask

    task automatic test_unaligned_single();
        mw_data[0] = 64'hDEAD_BEEF_0BAD_F00D; mw_strb[0] = 8'hF0;
        run_burst(2'd2, 32'h0000_1004, 3'd3, 8'd0, 1, -1, 0, 2'b00);
        checks++; if (cap_aw_addr !== 32'h1004 || cap_aw_len !== 8'd0) begin errors++; $display("FAIL unaligned_aw: got addr %h len %0d want 1004 0", cap_aw_addr, cap_aw_len); end
        checks++;
        if (got_data.size() != 1) begin
            errors++; $display("FAIL unaligned_count: got %0d want 1", got_data.size());
        end else if (got_data[0] !== 32'hDEAD_BEEF || got_strb[0] !== 4'hF || got_last[0] !== 1'b1) begin
            errors++; $display("FAIL unaligned_beat: got %h %h %b want deadbeef f 1", got_data[0], got_strb[0], got_last[0]);
        end
    endtask

    task automatic test_narrow_size();
        logic [31:0] exp_d[4];
        logic [3:0]  exp_s[4];
        mw_data[0] = 64'hFFFF_FFFF_A0A0_A0A0; mw_strb[0] = 8'h0F;
        mw_data[1] = 64'hB1B1_B1B1_FFFF_FFFF; mw_strb[1] = 8'hF0;
        mw_data[2] = 64'h0000_0000_C2C2_C2C2; mw_strb[2] = 8'h03;
        mw_data[3] = 64'hD3D3_D3D3_0000_0000; mw_strb[3] = 8'h80;
        exp_d = '{32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 32'hD3D3_D3D3};
        exp_s = '{4'hF, 4'hF, 4'h3, 4'h8};
        run_burst(2'd0, 32'h0000_2000, 3'd2, 8'd3, 4, -1, 0, 2'b00);
        checks++; if (cap_aw_len !== 8'd3 || cap_aw_size !== 3'd2) begin errors++; $display("FAIL narrow_aw: got len %0d size %0d want 3 2", cap_aw_len, cap_aw_size); end
        checks++; if (got_data.size() != 4) begin errors++; $display("FAIL narrow_count: got %0d want 4", got_data.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got_data.size()) begin
                errors++; $display("FAIL narrow_beat%0d: missing", i);
            end else if (got_data[i] !== exp_d[i] || got_strb[i] !== exp_s[i] || got_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL narrow_beat%0d: got %h %h %b want %h %h %b",
                         i, got_data[i], got_strb[i], got_last[i], exp_d[i], exp_s[i], i == 3);
            end
        end
    endtask

    task automatic test_stall_error();
        load_ab();
        run_burst(2'd3, 32'h0000_1000, 3'd3, 8'd1, 2, 1, 5, 2'b10);
        checks++; if (stall_violations != 0) begin errors++; $display("FAIL stall_w_ready: master_w_ready high in %0d stall cycles, want 0", stall_violations); end
        check_ab_beats("stall");
        checks++; if (cap_b_resp !== 2'b10) begin errors++; $display("FAIL stall_b_resp: got %b want 10", cap_b_resp); end
        checks++; if (cap_b_id !== 2'd3) begin errors++; $display("FAIL stall_b_id: got %0d want 3", cap_b_id); end
    endtask

    task automatic test_reset_mid_burst();
        send_aw(2'd1, 32'h0000_3000, 3'd3, 8'd1);
        accept_slave_aw();
        master_w_data = 64'hCAFE_F00D_1234_5678; master_w_strb = 8'hFF;
        master_w_last = 1'b0; master_w_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        master_w_valid = 1'b0;
        checks++; if (slave_w_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre: slave_w_valid %b want 1", slave_w_valid); end
        rstn = 1'b0;
        #1;
        checks++;
        if (slave_w_valid !== 1'b0 || slave_aw_valid !== 1'b0 || master_b_valid !== 1'b0 ||
            master_w_ready !== 1'b0 || slave_b_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valids: got w %b aw %b b %b wr %b br %b want all 0",
                     slave_w_valid, slave_aw_valid, master_b_valid, master_w_ready, slave_b_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (master_aw_ready !== 1'b1) begin errors++; $display("FAIL midreset_aw_ready: got %b want 1", master_aw_ready); end
        load_ab();
        run_burst(2'd2, 32'h0000_1000, 3'd3, 8'd1, 2, -1, 0, 2'b00);
        check_ab_beats("after_reset");
        checks++; if (cap_b_id !== 2'd2 || cap_b_resp !== 2'b00) begin errors++; $display("FAIL after_reset_b: got id %0d resp %b want 2 00", cap_b_id, cap_b_resp); end
    endtask

    initial begin
        master_aw_id = '0; master_aw_addr = '0; master_aw_len = '0; master_aw_size = '0;
        master_aw_burst = 2'b01; master_aw_lock = 1'b0; master_aw_cache = 4'h3; master_aw_prot = 3'h2;
        master_aw_qos = '0; master_aw_region = '0; master_aw_user = 1'b1; master_aw_valid = 1'b0;
        master_w_data = '0; master_w_strb = '0; master_w_last = 1'b0; master_w_user = 1'b0;
        master_w_valid = 1'b0; master_b_ready = 1'b0;
        slave_aw_ready = 1'b0; slave_w_ready = 1'b0;
        slave_b_id = '0; slave_b_resp = '0; slave_b_user = '0; slave_b_valid = 1'b0;
        stall_violations = 0;

        test_reset();
        test_aligned_burst();
        test_unaligned_single();
        test_narrow_size();
        test_stall_error();
        test_reset_mid_burst();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
